// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator.
package adsr_pkg;

  localparam logic [31:0] ENV_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } adsr_state_t;

endpackage

// File: rtl/env_vca.sv
// Two-stage VCA: registers sample/level, then scales the sample by level / 2^32.
import adsr_pkg::*;

module env_vca (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] sample,
  input  logic        valid,
  input  logic [31:0] level,
  output logic [31:0] amp_out,
  output logic        valid_out
);

  logic [31:0]        s1_sample;
  logic [31:0]        s1_level;
  logic               s1_valid;
  logic signed [64:0] sample_ext;
  logic signed [64:0] level_ext;
  logic signed [64:0] prod;
  logic               prod_unused;

  // Level is unsigned, so it is zero-extended before the signed multiply.
  assign sample_ext  = {{33{s1_sample[31]}}, s1_sample};
  assign level_ext   = {33'd0, s1_level};
  assign prod        = sample_ext * level_ext;
  assign prod_unused = ^{prod[64], prod[31:0]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_sample <= '0;
      s1_level  <= '0;
      s1_valid  <= 1'b0;
      amp_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      s1_valid  <= valid;
      valid_out <= s1_valid;
      if (valid) begin
        s1_sample <= sample;
        s1_level  <= level;
      end
      if (s1_valid) begin
        amp_out <= prod[63:32];
      end
    end
  end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope generator advanced on the oscillator sample tick, feeding a VCA.
//   state      | meaning
//   ST_IDLE    | no note, level held at 0
//   ST_ATTACK  | level rising by attack rate, saturating at ENV_MAX
//   ST_DECAY   | level falling by decay rate toward sustain
//   ST_SUSTAIN | level follows sustain_level_in
//   ST_RELEASE | level falling by release rate toward 0
import adsr_pkg::*;

module envelope_adsr (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        step_in,
  input  logic        gate_in,
  input  logic [31:0] attack_rate_in,
  input  logic [31:0] decay_rate_in,
  input  logic [31:0] sustain_level_in,
  input  logic [31:0] release_rate_in,
  input  logic [31:0] sample_in,
  input  logic        sample_valid_in,
  output logic [31:0] amp_out,
  output logic        valid_out,
  output logic [31:0] level_out,
  output logic        active_out
);

  adsr_state_t state, state_nxt;
  logic [31:0] level, level_nxt;
  logic        gate_prev, gate_prev_nxt;
  logic        gate_rise, gate_fall;
  logic [32:0] att_sum, dec_diff, rel_diff;

  assign gate_rise = gate_in & ~gate_prev;
  assign gate_fall = ~gate_in & gate_prev;

  // Bit 32 catches attack overflow and decay/release underflow.
  assign att_sum  = {1'b0, level} + {1'b0, attack_rate_in};
  assign dec_diff = {1'b0, level} - {1'b0, decay_rate_in};
  assign rel_diff = {1'b0, level} - {1'b0, release_rate_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      level     <= '0;
      gate_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      gate_prev <= gate_prev_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    level_nxt     = level;
    gate_prev_nxt = gate_prev;
    if (step_in) begin
      gate_prev_nxt = gate_in;
      if (gate_rise) begin
        state_nxt = ST_ATTACK;
      end else if (gate_fall && (state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
        state_nxt = ST_RELEASE;
      end else begin
        case (state)
          ST_IDLE: level_nxt = '0;
          ST_ATTACK: begin
            if (att_sum >= {1'b0, ENV_MAX}) begin
              level_nxt = ENV_MAX;
              state_nxt = ST_DECAY;
            end else begin
              level_nxt = att_sum[31:0];
            end
          end
          ST_DECAY: begin
            if (dec_diff[32] || (dec_diff[31:0] <= sustain_level_in)) begin
              level_nxt = sustain_level_in;
              state_nxt = ST_SUSTAIN;
            end else begin
              level_nxt = dec_diff[31:0];
            end
          end
          ST_SUSTAIN: level_nxt = sustain_level_in;
          ST_RELEASE: begin
            if (rel_diff[32] || (rel_diff[31:0] == 32'd0)) begin
              level_nxt = '0;
              state_nxt = ST_IDLE;
            end else begin
              level_nxt = rel_diff[31:0];
            end
          end
          default: begin
            level_nxt = '0;
            state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  assign level_out  = level;
  assign active_out = (state != ST_IDLE);

  env_vca u_vca (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .sample    (sample_in),
    .valid     (sample_valid_in),
    .level     (level),
    .amp_out   (amp_out),
    .valid_out (valid_out)
  );

endmodule

// File: doc/envelope_adsr.md
ENVELOPE_ADSR -- requirements
Module: envelope_adsr

Interface
REQ-001 Parameters: none; all widths fixed at 32 bits to match the oscillator sample format.
REQ-002 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 step_in  input  1  sample-rate tick, the same strobe that advances the sine oscillator; the envelope advances only on this tick.
REQ-005 gate_in  input  1  note on (1) / note off (0), level-sensitive, sampled only on step_in.
REQ-006 attack_rate_in  input  32  unsigned level increment per tick in ATTACK.
REQ-007 decay_rate_in  input  32  unsigned level decrement per tick in DECAY.
REQ-008 sustain_level_in  input  32  unsigned sustain level.
REQ-009 release_rate_in  input  32  unsigned level decrement per tick in RELEASE.
REQ-010 sample_in  input  32  signed oscillator sample.
REQ-011 sample_valid_in  input  1  qualifies sample_in for one cycle.
REQ-012 amp_out  output  32  signed enveloped sample.
REQ-013 valid_out  output  1  one-cycle pulse qualifying amp_out.
REQ-014 level_out  output  32  current unsigned envelope level.
REQ-015 active_out  output  1  high whenever state is not IDLE.

Function
REQ-016 States IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; transitions are evaluated only on cycles with step_in=1; the level register updates in the same cycle as the transition.
REQ-017 gate_prev is registered on each step_in; a rise means gate_in=1 and gate_prev=0; a fall means gate_in=0 and gate_prev=1.
REQ-018 A gate rise from any state goes to ATTACK without clearing the level (retrigger from the current level).
REQ-019 ATTACK: level = min(level + attack_rate_in, 0xFFFF_FFFF), computed 33-bit with no wrap; on reaching 0xFFFF_FFFF the state goes to DECAY; attack_rate_in=0 holds the level.
REQ-020 DECAY: if level - decay_rate_in <= sustain_level_in, or the subtraction underflows, the level is set to sustain_level_in and the state goes to SUSTAIN; otherwise the level is decremented.
REQ-021 SUSTAIN: level tracks sustain_level_in on every tick.
REQ-022 A gate fall while in ATTACK, DECAY or SUSTAIN moves the state to RELEASE on that tick, with the level unchanged on that tick.
REQ-023 RELEASE: level = max(level - release_rate_in, 0), with no wrap; at 0 the state goes to IDLE.
REQ-024 IDLE: level is held at 0.
REQ-025 Gate rise and fall take priority over the rate update of the same tick.
REQ-026 A gate pulse shorter than one tick period may be missed; this is accepted behaviour.
REQ-027 VCA stage 1: when sample_valid_in=1, register sample_in and level_out.
REQ-028 VCA stage 2: form the 65-bit signed product of sample × {1'b0, level}; amp_out = product[63:32] (arithmetic shift right by 32, floor); valid_out=1.
REQ-029 VCA latency is exactly 2 cycles from sample_valid_in to valid_out; a new sample is accepted every cycle.
REQ-030 step_in and sample_valid_in in the same cycle: stage 1 captures the pre-update level.

Reset
REQ-031 While rst_n_in=0: state=IDLE, level=0, gate_prev=0, amp_out=0, valid_out=0, active_out=0, VCA pipeline registers=0.
REQ-032 Reset mid-note aborts immediately; after release, a note starts only on a fresh gate rise at a tick (gate_in already high counts as a rise because gate_prev=0).

Structure
REQ-033 Package adsr_pkg holds the state enum typedef and the ENV_MAX=32'hFFFF_FFFF constant.
REQ-034 The two-stage multiply is sub-module env_vca (ports clk_in, rst_n_in, sample, valid, level, amp_out, valid_out); the FSM and level logic stay in envelope_adsr.

Verification
REQ-035 Attack: attack=0x4000_0000, decay=0x1000_0000, sustain=0x8000_0000, gate=1 at ticks -> level 0x4000_0000, 0x8000_0000, 0xC000_0000, 0xFFFF_FFFF (DECAY); then 7 decrements; 8th tick -> 0x8000_0000, SUSTAIN.
REQ-036 Release: from SUSTAIN 0x8000_0000, gate=0, release=0x3000_0000 -> next ticks 0x5000_0000, 0x2000_0000, 0 with IDLE and active_out=0.
REQ-037 Retrigger: gate 0->1 in RELEASE at level 0x2000_0000 with attack=0x4000_0000 -> ATTACK; level 0x6000_0000 on the following tick.
REQ-038 VCA: level 0xFFFF_FFFF, sample 0x4000_0000 -> amp_out 0x3FFF_FFFF two cycles later; sample 0xC000_0000 -> 0xC000_0000; level 0 -> 0.
REQ-039 Back-to-back sample_valid_in on 4 consecutive cycles -> 4 consecutive valid_out pulses, in order, 2-cycle latency.
REQ-040 Assert rst_n_in low mid-ATTACK asynchronously (between clock edges) -> all outputs 0 immediately; with gate held at 1, ATTACK resumes on the first tick after reset release.
